// File: rtl/jt10_adpcm_pkg.sv
// Shared definitions for the ADPCM-A control block: register map,
// FSM encoding and small decode helpers.
package jt10_adpcm_pkg;

    // Register indices (base of each 6-channel group)
    localparam logic [7:0] REG_KEY      = 8'h00;
    localparam logic [7:0] REG_START_LO = 8'h10;
    localparam logic [7:0] REG_START_HI = 8'h18;
    localparam logic [7:0] REG_END_LO   = 8'h20;
    localparam logic [7:0] REG_END_HI   = 8'h28;

    localparam int NUM_CH = 6;

    // Address update FSM
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // True when idx falls inside the 6-channel group starting at base
    function automatic logic in_group(input logic [7:0] idx, input logic [7:0] base);
        return (idx[7:3] == base[7:3]) && (idx[2:0] < 3'd6);
    endfunction

    // Channel number to one-hot slot mask
    function automatic logic [5:0] onehot6(input logic [2:0] ch);
        return 6'b000001 << ch;
    endfunction

endpackage

// File: rtl/jt10_adpcm_slot.sv
// Six-slot pipeline rotation and once-per-frame decimation enable.
module jt10_adpcm_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    output logic [5:0] cur_ch,
    output logic [5:0] en_ch
);

    logic [5:0] cur_ch_reg;
    logic [5:0] en_ch_reg;

    // Rotate the slot every cen; rotate the decimation enable at frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch_reg <= 6'b000001;
            en_ch_reg  <= 6'b000001;
        end else if (cen) begin
            cur_ch_reg <= {cur_ch_reg[4:0], cur_ch_reg[5]};
            if (cur_ch_reg[5])
                en_ch_reg <= {en_ch_reg[4:0], en_ch_reg[5]};
        end
    end

    assign cur_ch = cur_ch_reg;
    assign en_ch  = en_ch_reg;

endmodule

// File: rtl/jt10_adpcm_ctl.sv
// ADPCM-A control: CPU register decode, start/end address commit with a
// wait-for-slot handshake, and per-channel key-on/key-off pending flags.
module jt10_adpcm_ctl
    import jt10_adpcm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr,
    input  logic [7:0]  addr,
    input  logic [7:0]  din,
    output logic [5:0]  cur_ch,
    output logic [5:0]  en_ch,
    output logic [15:0] addr_in,
    output logic [2:0]  addr_ch,
    output logic        up_start,
    output logic        up_end,
    output logic        aon,
    output logic        aoff,
    output logic        busy,
    output logic        ovf
);

    jt10_adpcm_slot u_slot (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .cur_ch (cur_ch),
        .en_ch  (en_ch)
    );

    // Write decode
    logic key_wr, start_lo_wr, start_hi_wr, end_lo_wr, end_hi_wr, commit_wr;
    assign key_wr      = wr && (addr == REG_KEY);
    assign start_lo_wr = wr && in_group(addr, REG_START_LO);
    assign start_hi_wr = wr && in_group(addr, REG_START_HI);
    assign end_lo_wr   = wr && in_group(addr, REG_END_LO);
    assign end_hi_wr   = wr && in_group(addr, REG_END_HI);
    assign commit_wr   = start_hi_wr || end_hi_wr;

    logic [7:0] start_lo_reg;
    logic [7:0] end_lo_reg;

    // Low-byte shadows, written in any FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            start_lo_reg <= 8'h00;
            end_lo_reg   <= 8'h00;
        end else begin
            if (start_lo_wr) start_lo_reg <= din;
            if (end_lo_wr)   end_lo_reg   <= din;
        end
    end

    state_t      state_reg;
    logic [15:0] addr_in_reg;
    logic [2:0]  addr_ch_reg;
    logic        up_start_reg, up_end_reg, busy_reg, ovf_reg;

    // Address commit FSM: hold the request until the target slot's cen
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            addr_in_reg  <= 16'h0000;
            addr_ch_reg  <= 3'd0;
            up_start_reg <= 1'b0;
            up_end_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            if (key_wr && din == 8'hFF)
                ovf_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (commit_wr) begin
                        state_reg    <= ST_WAIT;
                        addr_in_reg  <= {din, start_hi_wr ? start_lo_reg : end_lo_reg};
                        addr_ch_reg  <= addr[2:0];
                        up_start_reg <= start_hi_wr;
                        up_end_reg   <= end_hi_wr;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A second commit while one is outstanding is lost
                    if (commit_wr)
                        ovf_reg <= 1'b1;
                    if (cen && cur_ch == onehot6(addr_ch_reg)) begin
                        state_reg    <= ST_IDLE;
                        up_start_reg <= 1'b0;
                        up_end_reg   <= 1'b0;
                        busy_reg     <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign addr_in  = addr_in_reg;
    assign addr_ch  = addr_ch_reg;
    assign up_start = up_start_reg;
    assign up_end   = up_end_reg;
    assign busy     = busy_reg;
    assign ovf      = ovf_reg;

    logic [5:0] aon_pend_reg,  aon_pend_next;
    logic [5:0] aoff_pend_reg, aoff_pend_next;

    // Per-channel key flags: slot clear, with a same-clk write taking priority.
    // Key-off beats key-on, both within one write and against an older key-off.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_key
        logic clr, off_keep, on_set, off_set;
        assign clr      = cen && cur_ch[gi];
        assign off_keep = aoff_pend_reg[gi] && !clr;
        assign off_set  = key_wr && din[7] && din[gi];
        assign on_set   = key_wr && !din[7] && din[gi] && !off_keep;
        assign aoff_pend_next[gi] = off_keep || off_set;
        assign aon_pend_next[gi]  = (aon_pend_reg[gi] && !clr && !off_set) || on_set;
    end

    // Key pending registers
    always_ff @(posedge clk) begin
        if (rst) begin
            aon_pend_reg  <= 6'd0;
            aoff_pend_reg <= 6'd0;
        end else begin
            aon_pend_reg  <= aon_pend_next;
            aoff_pend_reg <= aoff_pend_next;
        end
    end

    assign aon  = |(aon_pend_reg & cur_ch);
    assign aoff = |(aoff_pend_reg & cur_ch);

endmodule
